instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Parametrised, byte-addressed, big-endian instruction memory for the ARM pipeline IF stage.
- Adds three things: a self-clearing reset sequence, a word-wide program-load port with a valid/ready handshake, and a registered fetch port with stall hold and fault reporting.
- Sits between the PC register and the IF/ID register.
- The testbench or a boot loader streams programs in through the load port; nothing is hardcoded.

Parameters:
- DATA_W, 32, instruction width in bits; must be a multiple of 8.
- DEPTH_WORDS, 64, number of instruction words stored; byte capacity is DEPTH_WORDS*DATA_W/8.
- ADDR_W, 32, width of the fetch byte address.
- NOP_WORD, 32'hE000_0000, fill value after reset and value returned on fault or when not ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_start  in  1  pulse; begins a program load at word 0. Honoured only in IDLE.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  memory accepts a word this cycle.
- load_data  in  DATA_W  instruction word to store.
- load_last  in  1  qualifies the final word of a load.
- load_ovf  out  1  sticky flag: a load filled the memory without load_last.
- mem_ready  out  1  high only in IDLE; fetches are serviced.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address (PC).
- fetch_stall  in  1  hold the current fetch output.
- fetch_instr  out  DATA_W  registered instruction.
- fetch_valid  out  1  fetch_instr holds a serviced fetch.
- fetch_fault  out  1  last fetch was misaligned or out of range.

Behaviour:
- Storage: byte array of DEPTH_WORDS*DATA_W/8 entries.
  - Word w occupies bytes 4w..4w+3.
  - Byte 4w holds bits [DATA_W-1:DATA_W-8] (big-endian).
- States: CLEAR, IDLE, LOAD (2-bit FSM). Internal word pointer ptr, width clog2(DEPTH_WORDS).
- Reset, rst=1 at a clock edge:
  - state<=CLEAR, ptr<=0, load_ovf<=0.
  - fetch_instr<=NOP_WORD, fetch_valid<=0, fetch_fault<=0.
  - load_ready=0, mem_ready=0.
  - Reset mid-load or mid-clear restarts CLEAR; all partial content is discarded.
- CLEAR:
  - Writes NOP_WORD to word ptr each cycle and increments ptr.
  - After writing word DEPTH_WORDS-1: ptr<=0, state<=IDLE.
  - Total length is exactly DEPTH_WORDS cycles after rst deasserts.
- IDLE:
  - mem_ready=1, load_ready=0.
  - load_start=1 → state<=LOAD, ptr<=0, load_ovf<=0.
  - The fetch in the same cycle as load_start is still serviced.
- LOAD:
  - mem_ready=0, load_ready=1.
  - On load_valid & load_ready: write load_data to word ptr, then ptr<=ptr+1.
  - If load_last → state<=IDLE, ptr<=0.
  - Else if ptr==DEPTH_WORDS-1 → state<=IDLE, ptr<=0, load_ovf<=1. Any further words are not accepted (load_ready=0).
  - load_start in LOAD is ignored.
- Fetch, 1-cycle latency, evaluated at each clock edge when not in reset:
  - fetch_stall=1 → fetch_instr, fetch_valid and fetch_fault hold, regardless of fetch_req. Stall has priority.
  - Else if mem_ready=0 or fetch_req=0 → fetch_valid<=0, fetch_fault<=0, fetch_instr<=NOP_WORD.
  - Else fetch_valid<=1, and:
    - Misaligned (fetch_addr[1:0]!=0) or out of range (fetch_addr > bytes-4) → fetch_fault<=1, fetch_instr<=NOP_WORD.
    - Otherwise fetch_fault<=0, fetch_instr<={mem[a],mem[a+1],mem[a+2],mem[a+3]}.
  - Range comparison uses full ADDR_W; upper address bits are not truncated and do not alias.
- Simultaneous load write and fetch cannot occur: they are mutually exclusive by state.
- Transition cycle LOAD→IDLE:
  - mem_ready rises the following cycle.
  - The first fetch after a load sees the newly written word.
- No combinational path from load_* inputs to load_ready; load_ready is a function of state only.

Test Plan:
- Reset clear:
  - Stimulus: assert rst 2 cycles, release, wait 64 cycles, fetch 0x00 and 0xFC.
  - Required: mem_ready rises exactly 64 cycles after release; both fetches return 0xE000_0000, valid=1, fault=0.
- Load and fetch:
  - Stimulus: load 3 words 0xE3A0_0014, 0xE3A0_1A01, 0xE3A0_2103 with load_last on the third; fetch 0x04.
  - Required: 0xE3A0_1A01 one cycle later; word 3 still reads NOP.
- Load handshake bubbles:
  - Stimulus: toggle load_valid 1,0,1,0,1 with load_last on the third beat.
  - Required: exactly 3 words written at indices 0..2; state returns to IDLE.
- Overflow:
  - Stimulus: stream 65 words with no load_last.
  - Required: first 64 stored; load_ovf=1; load_ready=0 on beat 65; the 65th word is not written.
- Faults:
  - Stimulus: fetch 0x06, 0x100, 0xFFFF_FF00.
  - Required: each gives fetch_valid=1, fetch_fault=1, fetch_instr=0xE000_0000.
- Stall and reset mid-load:
  - Stimulus: fetch 0x00, then stall 3 cycles while fetch_addr changes.
  - Required: output held at the word-0 value throughout.
  - Stimulus: assert rst after 2 load beats.
  - Required: CLEAR restarts and afterwards word 0 reads 0xE000_0000.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable big-endian instruction memory for the IF stage.
// CLEAR fills every word with NOP_WORD after reset. LOAD streams words in over a
// valid/ready port. IDLE serves registered fetches with stall hold and fault reporting.
module instr_mem_loadable #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 64,
  parameter int                ADDR_W      = 32,
  parameter logic [DATA_W-1:0] NOP_WORD    = 32'hE000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ovf,
  output logic              mem_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              fetch_fault
);

  localparam int BPW     = DATA_W / 8;
  localparam int BYTES   = DEPTH_WORDS * BPW;
  localparam int PTR_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BYTE_AW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BYTES - BPW);
  localparam logic [ADDR_W-1:0] ADDR_BPW  = ADDR_W'(BPW);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               fvalid_q, fvalid_d;
  logic               ffault_q, ffault_d;

  logic [7:0]         mem [BYTES];
  logic               we;
  logic [DATA_W-1:0]  wdata;
  logic [PTR_W-1:0]   ridx;
  logic [DATA_W-1:0]  rdata;
  logic               bad_addr;

  // Handshake outputs depend on state only, so there is no comb path from load_* inputs.
  assign load_ready  = (state_q == S_LOAD);
  assign mem_ready   = (state_q == S_IDLE);
  assign load_ovf    = ovf_q;
  assign fetch_instr = instr_q;
  assign fetch_valid = fvalid_q;
  assign fetch_fault = ffault_q;

  // Next state, pointer, overflow flag and write strobe for the clear and load sequences.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wdata   = NOP_WORD;
    unique case (state_q)
      S_CLEAR: begin
        we = 1'b1;
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          we    = 1'b1;
          wdata = load_data;
          if (load_last) begin
            state_d = S_IDLE;
            ptr_d   = '0;
          end else if (ptr_q == PTR_LAST) begin
            // Memory full with no terminating word: stop accepting and flag it.
            state_d = S_IDLE;
            ptr_d   = '0;
            ovf_d   = 1'b1;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State registers; a reset at any point restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Word write into the byte array, most significant byte at the lowest address.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int b = 0; b < BPW; b++) begin
        mem[BYTE_AW'(int'(ptr_q) * BPW + b)] <= wdata[DATA_W-1-8*b -: 8];
      end
    end
  end

  // Full-width address checks: high address bits must not alias into the array.
  assign bad_addr = ((fetch_addr % ADDR_BPW) != '0) || (fetch_addr > ADDR_LAST);
  assign ridx     = PTR_W'(fetch_addr / ADDR_BPW);

  // Big-endian word assembly for the fetch address.
  always_comb begin
    rdata = '0;
    for (int b = 0; b < BPW; b++) begin
      rdata[DATA_W-1-8*b -: 8] = mem[BYTE_AW'(int'(ridx) * BPW + b)];
    end
  end

  // Fetch next-state: stall holds everything, otherwise serve or return NOP.
  always_comb begin
    instr_d  = instr_q;
    fvalid_d = fvalid_q;
    ffault_d = ffault_q;
    if (!fetch_stall) begin
      if (!mem_ready || !fetch_req) begin
        instr_d  = NOP_WORD;
        fvalid_d = 1'b0;
        ffault_d = 1'b0;
      end else begin
        fvalid_d = 1'b1;
        ffault_d = bad_addr;
        instr_d  = bad_addr ? NOP_WORD : rdata;
      end
    end
  end

  // Registered fetch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= NOP_WORD;
      fvalid_q <= 1'b0;
      ffault_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      fvalid_q <= fvalid_d;
      ffault_q <= ffault_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: clear sequence, loads, bubbles,
// overflow, fetch faults, stall hold and reset in the middle of a load.
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, load_ovf, mem_ready;
  logic        fetch_req, fetch_stall;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_valid, fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] ld_data [0:64];

  always #5 clk = ~clk;

  instr_mem_loadable dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ovf   (load_ovf),
    .mem_ready  (mem_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges from reset release until mem_ready rises (bounded).
  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (!mem_ready && cnt < 200) begin
      tick();
      cnt++;
    end
    check(tag, 64'(cnt), 64'd64);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_i,
                          input logic exp_f);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    check({tag, "_instr"}, 64'(fetch_instr), 64'(exp_i));
    check({tag, "_valid"}, 64'(fetch_valid), 64'd1);
    check({tag, "_fault"}, 64'(fetch_fault), 64'(exp_f));
  endtask

  task automatic do_load(input int n, input bit use_last);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_ready_in_load", 64'(load_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = ld_data[i];
      load_last  = use_last && (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bdata [0:2];
    logic        bvld  [0:4];
    int k;
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    fetch_req = 1'b0; fetch_stall = 1'b0; fetch_addr = '0;

    // Reset state and clear length.
    repeat (2) tick();
    check("rst_mem_ready",  64'(mem_ready),   64'd0);
    check("rst_load_ready", 64'(load_ready),  64'd0);
    check("rst_ovf",        64'(load_ovf),    64'd0);
    check("rst_valid",      64'(fetch_valid), 64'd0);
    check("rst_fault",      64'(fetch_fault), 64'd0);
    check("rst_instr",      64'(fetch_instr), 64'(NOP));
    rst = 1'b0;
    wait_clear("clear_len");
    do_fetch("clr_w0",  32'h00, NOP, 1'b0);
    do_fetch("clr_w63", 32'hFC, NOP, 1'b0);

    // Three-word program load and fetch.
    ld_data[0] = 32'hE3A0_0014; ld_data[1] = 32'hE3A0_1A01; ld_data[2] = 32'hE3A0_2103;
    do_load(3, 1'b1);
    check("load_done_ready", 64'(mem_ready), 64'd1);
    do_fetch("ld_w1", 32'h04, 32'hE3A0_1A01, 1'b0);
    do_fetch("ld_w3", 32'h0C, NOP, 1'b0);

    // Faults: misaligned, one past the end, high bits set.
    do_fetch("f_mis",  32'h06,        NOP, 1'b1);
    do_fetch("f_end",  32'h100,       NOP, 1'b1);
    do_fetch("f_high", 32'hFFFF_FF00, NOP, 1'b1);

    // Stall holds word 0 while address and request change.
    do_fetch("st_w0", 32'h00, 32'hE3A0_0014, 1'b0);
    fetch_stall = 1'b1;
    fetch_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(4 * (i + 1));
      tick();
      check("stall_instr", 64'(fetch_instr), 64'hE3A0_0014);
      check("stall_valid", 64'(fetch_valid), 64'd1);
    end
    fetch_stall = 1'b0;
    fetch_req   = 1'b0;
    tick();
    check("unstall_idle", 64'(fetch_valid), 64'd0);

    // Bubbled load: valid 1,0,1,0,1, last on third accepted beat.
    bdata[0] = 32'h1111_1111; bdata[1] = 32'h2222_2222; bdata[2] = 32'h3333_3333;
    bvld[0] = 1; bvld[1] = 0; bvld[2] = 1; bvld[3] = 0; bvld[4] = 1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = bvld[i];
      load_data  = bvld[i] ? bdata[k] : 32'hDEAD_BEEF;
      load_last  = bvld[i] && (k == 2);
      fetch_req  = (i == 0);
      fetch_addr = 32'h0;
      tick();
      if (bvld[i]) k++;
      if (i == 0) check("fetch_in_load", 64'(fetch_valid), 64'd0);
      if (i == 3) check("bub_still_load", 64'(load_ready), 64'd1);
    end
    load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
    check("bub_idle", 64'(mem_ready), 64'd1);
    do_fetch("bub_w0", 32'h00, 32'h1111_1111, 1'b0);
    do_fetch("bub_w1", 32'h04, 32'h2222_2222, 1'b0);
    do_fetch("bub_w2", 32'h08, 32'h3333_3333, 1'b0);
    do_fetch("bub_w3", 32'h0C, NOP, 1'b0);

    // Overflow: 64 words fill memory, the 65th is refused.
    for (int i = 0; i < 65; i++) ld_data[i] = 32'hA000_0000 + 32'(i);
    do_load(64, 1'b0);
    check("ovf_flag",  64'(load_ovf),   64'd1);
    check("ovf_ready", 64'(load_ready), 64'd0);
    check("ovf_idle",  64'(mem_ready),  64'd1);
    load_valid = 1'b1;
    load_data  = ld_data[64];
    tick();
    load_valid = 1'b0;
    do_fetch("ovf_w0",  32'h00, 32'hA000_0000, 1'b0);
    do_fetch("ovf_w32", 32'h80, 32'hA000_0020, 1'b0);
    do_fetch("ovf_w63", 32'hFC, 32'hA000_003F, 1'b0);
    check("ovf_sticky", 64'(load_ovf), 64'd1);

    // A new load clears the flag; reset two beats in restarts CLEAR.
    ld_data[0] = 32'h5555_5555; ld_data[1] = 32'h6666_6666;
    do_load(2, 1'b0);
    check("ovf_cleared", 64'(load_ovf), 64'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_load_ready", 64'(load_ready), 64'd0);
    check("mid_rst_mem_ready",  64'(mem_ready),  64'd0);
    rst = 1'b0;
    wait_clear("reclear_len");
    do_fetch("rc_w0", 32'h00, NOP, 1'b0);
    do_fetch("rc_w1", 32'h04, NOP, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
